// File: rtl/alu_reservation_station_if.sv
// Dispatch / CDB / issue bundle for the ALU reservation station.
// The master side is the surrounding core (dispatch, CDB, ALU); the
// station itself connects through the slave modport.
interface alu_reservation_station_if #(
   parameter int XLEN      = 32,
   parameter int RS_SIZE   = 8,
   parameter int TAG_WIDTH = 6
);
   logic                       flush;

   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [3:0]                 alloc_alu_op;
   logic [TAG_WIDTH-1:0]       alloc_rob_tag;
   logic [XLEN-1:0]            alloc_src1_value;
   logic [XLEN-1:0]            alloc_src2_value;
   logic                       alloc_src1_ready;
   logic                       alloc_src2_ready;
   logic [TAG_WIDTH-1:0]       alloc_src1_tag;
   logic [TAG_WIDTH-1:0]       alloc_src2_tag;

   logic                       cdb_valid;
   logic [TAG_WIDTH-1:0]       cdb_tag;
   logic [XLEN-1:0]            cdb_value;

   logic                       issue_valid;
   logic                       issue_ready;
   logic [3:0]                 issue_alu_op;
   logic [XLEN-1:0]            issue_src1;
   logic [XLEN-1:0]            issue_src2;
   logic [TAG_WIDTH-1:0]       issue_rob_tag;

   logic [$clog2(RS_SIZE):0]   occupancy;

   modport master (
      output flush,
      output alloc_valid, alloc_alu_op, alloc_rob_tag,
      output alloc_src1_value, alloc_src2_value,
      output alloc_src1_ready, alloc_src2_ready,
      output alloc_src1_tag, alloc_src2_tag,
      input  alloc_ready,
      output cdb_valid, cdb_tag, cdb_value,
      input  issue_valid, issue_alu_op, issue_src1, issue_src2, issue_rob_tag,
      output issue_ready,
      input  occupancy
   );

   modport slave (
      input  flush,
      input  alloc_valid, alloc_alu_op, alloc_rob_tag,
      input  alloc_src1_value, alloc_src2_value,
      input  alloc_src1_ready, alloc_src2_ready,
      input  alloc_src1_tag, alloc_src2_tag,
      output alloc_ready,
      input  cdb_valid, cdb_tag, cdb_value,
      output issue_valid, issue_alu_op, issue_src1, issue_src2, issue_rob_tag,
      input  issue_ready,
      output occupancy
   );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: age-ordered collapsing queue (slot 0 oldest).
// Holds renamed micro-ops until both sources are ready, snoops the CDB for
// missing operands, and issues the oldest ready entry to the ALU.
module alu_reservation_station #(
   parameter int XLEN      = 32,
   parameter int RS_SIZE   = 8,
   parameter int TAG_WIDTH = 6
) (
   input logic                   clk,
   input logic                   rst,
   alu_reservation_station_if.slave rs_if
);
   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int OCC_W = $clog2(RS_SIZE) + 1;

   typedef struct packed {
      logic                 valid;
      logic [3:0]           alu_op;
      logic [TAG_WIDTH-1:0] rob_tag;
      logic                 src1_ready;
      logic [TAG_WIDTH-1:0] src1_tag;
      logic [XLEN-1:0]      src1_value;
      logic                 src2_ready;
      logic [TAG_WIDTH-1:0] src2_tag;
      logic [XLEN-1:0]      src2_value;
   } entry_t;

   entry_t             entry_q [RS_SIZE];
   entry_t             entry_d [RS_SIZE];
   entry_t             woken   [RS_SIZE];
   entry_t             new_entry;
   logic [OCC_W-1:0]   occ_q;
   logic [OCC_W-1:0]   occ_d;
   logic [OCC_W-1:0]   alloc_slot;
   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic               issue_valid;
   logic               issue_fire;
   logic               alloc_ready;
   logic               alloc_fire;

   assign alloc_ready = (occ_q < OCC_W'(RS_SIZE));
   assign alloc_fire  = rs_if.alloc_valid && alloc_ready && !rs_if.flush;
   assign issue_valid = sel_found && !rs_if.flush;
   assign issue_fire  = issue_valid && rs_if.issue_ready;
   // The issued slot collapses, so the tail moves down by one when issuing.
   assign alloc_slot  = occ_q - OCC_W'(issue_fire);

   // Wakeup: each waiting source matching the CDB tag becomes ready.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         // NOTE: assign a full default before any conditional update so no latch is inferred.
         woken[i] = entry_q[i];
         if (rs_if.cdb_valid && entry_q[i].valid) begin
            if (!entry_q[i].src1_ready && (entry_q[i].src1_tag == rs_if.cdb_tag)) begin
               woken[i].src1_ready = 1'b1;
               woken[i].src1_value = rs_if.cdb_value;
            end
            if (!entry_q[i].src2_ready && (entry_q[i].src2_tag == rs_if.cdb_tag)) begin
               woken[i].src2_ready = 1'b1;
               woken[i].src2_value = rs_if.cdb_value;
            end
         end
      end
   end

   // Incoming micro-op, with operands bypassed from a same-cycle CDB broadcast.
   always_comb begin
      new_entry            = '0;
      new_entry.valid      = 1'b1;
      new_entry.alu_op     = rs_if.alloc_alu_op;
      new_entry.rob_tag    = rs_if.alloc_rob_tag;
      new_entry.src1_ready = rs_if.alloc_src1_ready;
      new_entry.src1_tag   = rs_if.alloc_src1_tag;
      new_entry.src1_value = rs_if.alloc_src1_value;
      new_entry.src2_ready = rs_if.alloc_src2_ready;
      new_entry.src2_tag   = rs_if.alloc_src2_tag;
      new_entry.src2_value = rs_if.alloc_src2_value;
      if (rs_if.cdb_valid && !rs_if.alloc_src1_ready && (rs_if.alloc_src1_tag == rs_if.cdb_tag)) begin
         new_entry.src1_ready = 1'b1;
         new_entry.src1_value = rs_if.cdb_value;
      end
      if (rs_if.cdb_valid && !rs_if.alloc_src2_ready && (rs_if.alloc_src2_tag == rs_if.cdb_tag)) begin
         new_entry.src2_ready = 1'b1;
         new_entry.src2_value = rs_if.cdb_value;
      end
   end

   // Select: the lowest-index entry with both sources ready wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (entry_q[i].valid && entry_q[i].src1_ready && entry_q[i].src2_ready) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // Next state: collapse above the issued slot, append the new entry, flush.
   always_comb begin
      for (int i = 0; i < RS_SIZE - 1; i++) begin
         if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
            entry_d[i] = woken[i+1];
         end else begin
            entry_d[i] = woken[i];
         end
      end
      if (issue_fire) begin
         entry_d[RS_SIZE-1] = '0;
      end else begin
         entry_d[RS_SIZE-1] = woken[RS_SIZE-1];
      end

      for (int i = 0; i < RS_SIZE; i++) begin
         if (alloc_fire && (alloc_slot == OCC_W'(i))) begin
            entry_d[i] = new_entry;
         end
      end

      occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);

      if (rs_if.flush) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i].valid = 1'b0;
         end
         occ_d = '0;
      end
   end

   // State registers; reset clears only the valid bits and the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
         // NOTE: payload fields are don't-care while invalid, so only valid bits are reset.
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i].valid <= 1'b0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         occ_q <= occ_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

   assign rs_if.alloc_ready   = alloc_ready;
   assign rs_if.occupancy     = occ_q;
   assign rs_if.issue_valid   = issue_valid;
   assign rs_if.issue_alu_op  = issue_valid ? entry_q[sel_idx].alu_op     : '0;
   assign rs_if.issue_rob_tag = issue_valid ? entry_q[sel_idx].rob_tag    : '0;
   assign rs_if.issue_src1    = issue_valid ? entry_q[sel_idx].src1_value : '0;
   assign rs_if.issue_src2    = issue_valid ? entry_q[sel_idx].src2_value : '0;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed testbench for alu_reservation_station.
module tb_alu_reservation_station;
   localparam int XLEN = 32;
   localparam int RS_SIZE = 8;
   localparam int TAG_WIDTH = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_reservation_station_if #(.XLEN(XLEN), .RS_SIZE(RS_SIZE), .TAG_WIDTH(TAG_WIDTH)) rs_if ();

   alu_reservation_station #(.XLEN(XLEN), .RS_SIZE(RS_SIZE), .TAG_WIDTH(TAG_WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .rs_if(rs_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      rs_if.flush = 1'b0;
      rs_if.alloc_valid = 1'b0;
      rs_if.alloc_alu_op = '0;
      rs_if.alloc_rob_tag = '0;
      rs_if.alloc_src1_value = '0;
      rs_if.alloc_src2_value = '0;
      rs_if.alloc_src1_ready = 1'b0;
      rs_if.alloc_src2_ready = 1'b0;
      rs_if.alloc_src1_tag = '0;
      rs_if.alloc_src2_tag = '0;
      rs_if.cdb_valid = 1'b0;
      rs_if.cdb_tag = '0;
      rs_if.cdb_value = '0;
      rs_if.issue_ready = 1'b0;
   endtask

   task automatic drive_alloc(input logic [3:0] op, input logic [5:0] tag,
                              input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                              input logic r2, input logic [5:0] t2, input logic [31:0] v2);
      rs_if.alloc_valid = 1'b1;
      rs_if.alloc_alu_op = op;
      rs_if.alloc_rob_tag = tag;
      rs_if.alloc_src1_ready = r1;
      rs_if.alloc_src1_tag = t1;
      rs_if.alloc_src1_value = v1;
      rs_if.alloc_src2_ready = r2;
      rs_if.alloc_src2_tag = t2;
      rs_if.alloc_src2_value = v2;
   endtask

   task automatic do_flush();
      rs_if.flush = 1'b1;
      tick();
      rs_if.flush = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      settle();
      checks++; if (rs_if.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=1", rs_if.alloc_ready); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b exp=0", rs_if.issue_valid); end
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", rs_if.occupancy); end
      checks++; if ({rs_if.issue_src1, rs_if.issue_src2, rs_if.issue_rob_tag, rs_if.issue_alu_op} !== '0) begin
         failures++; $display("FAIL reset_issue_fields got=%0h/%0h/%0h/%0h exp=0", rs_if.issue_src1, rs_if.issue_src2, rs_if.issue_rob_tag, rs_if.issue_alu_op);
      end
   endtask

   task automatic test_basic_issue();
      rs_if.issue_ready = 1'b1;
      drive_alloc(4'h0, 6'd5, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
      settle();
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL basic_no_early_issue got=%0b exp=0", rs_if.issue_valid); end
      tick();
      rs_if.alloc_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL basic_issue_valid got=%0b exp=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_src1 !== 32'd3) begin failures++; $display("FAIL basic_src1 got=%0h exp=3", rs_if.issue_src1); end
      checks++; if (rs_if.issue_src2 !== 32'd4) begin failures++; $display("FAIL basic_src2 got=%0h exp=4", rs_if.issue_src2); end
      checks++; if (rs_if.issue_rob_tag !== 6'd5) begin failures++; $display("FAIL basic_tag got=%0d exp=5", rs_if.issue_rob_tag); end
      checks++; if (rs_if.occupancy !== 4'd1) begin failures++; $display("FAIL basic_occ_before got=%0d exp=1", rs_if.occupancy); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL basic_occ_after got=%0d exp=0", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL basic_issue_cleared got=%0b exp=0", rs_if.issue_valid); end
   endtask

   task automatic test_cdb_wakeup();
      rs_if.issue_ready = 1'b1;
      drive_alloc(4'h1, 6'd7, 1'b1, 6'd0, 32'h11, 1'b0, 6'd12, 32'h0);
      tick();
      rs_if.alloc_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_waiting got=%0b exp=0", rs_if.issue_valid); end
      tick();
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd12;
      rs_if.cdb_value = 32'hDEAD;
      settle();
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got=%0b exp=0", rs_if.issue_valid); end
      tick();
      rs_if.cdb_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL wake_issue_valid got=%0b exp=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_src2 !== 32'hDEAD) begin failures++; $display("FAIL wake_src2 got=%0h exp=dead", rs_if.issue_src2); end
      checks++; if (rs_if.issue_src1 !== 32'h11) begin failures++; $display("FAIL wake_src1 got=%0h exp=11", rs_if.issue_src1); end
      checks++; if (rs_if.issue_rob_tag !== 6'd7) begin failures++; $display("FAIL wake_tag got=%0d exp=7", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_alu_op !== 4'h1) begin failures++; $display("FAIL wake_op got=%0h exp=1", rs_if.issue_alu_op); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL wake_occ_after got=%0d exp=0", rs_if.occupancy); end
   endtask

   task automatic test_alloc_bypass();
      rs_if.issue_ready = 1'b1;
      // src2 is already ready with a coincident tag; it must keep its own value.
      drive_alloc(4'h2, 6'd8, 1'b0, 6'd9, 32'h0, 1'b1, 6'd9, 32'h66);
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd9;
      rs_if.cdb_value = 32'h55;
      tick();
      rs_if.alloc_valid = 1'b0;
      rs_if.cdb_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL bypass_issue_valid got=%0b exp=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_src1 !== 32'h55) begin failures++; $display("FAIL bypass_src1 got=%0h exp=55", rs_if.issue_src1); end
      checks++; if (rs_if.issue_src2 !== 32'h66) begin failures++; $display("FAIL bypass_src2_kept got=%0h exp=66", rs_if.issue_src2); end
      checks++; if (rs_if.issue_rob_tag !== 6'd8) begin failures++; $display("FAIL bypass_tag got=%0d exp=8", rs_if.issue_rob_tag); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL bypass_occ_after got=%0d exp=0", rs_if.occupancy); end
   endtask

   task automatic test_fill_select();
      rs_if.issue_ready = 1'b0;
      // Entry i: rob tag 20+i, src1 ready = i, src2 waits on 40+i (entries 2 and 5 share tag 50).
      for (int i = 0; i < RS_SIZE; i++) begin
         drive_alloc(4'h3, 6'(20 + i), 1'b1, 6'd0, 32'(i), 1'b0,
                     (i == 2 || i == 5) ? 6'd50 : 6'(40 + i), 32'h0);
         tick();
      end
      // Extra allocation while full must be dropped.
      drive_alloc(4'h4, 6'd60, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
      settle();
      checks++; if (rs_if.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_alloc_ready got=%0b exp=0", rs_if.alloc_ready); end
      checks++; if (rs_if.occupancy !== 4'd8) begin failures++; $display("FAIL fill_occ got=%0d exp=8", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL fill_none_ready got=%0b exp=0", rs_if.issue_valid); end
      tick();
      rs_if.alloc_valid = 1'b0;
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd50;
      rs_if.cdb_value = 32'hAB;
      tick();
      rs_if.cdb_valid = 1'b0;
      rs_if.issue_ready = 1'b1;
      // Allocate and issue while full: only the issue takes effect.
      drive_alloc(4'h4, 6'd61, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
      settle();
      checks++; if (rs_if.occupancy !== 4'd8) begin failures++; $display("FAIL fill_drop_occ got=%0d exp=8", rs_if.occupancy); end
      checks++; if (rs_if.issue_rob_tag !== 6'd22) begin failures++; $display("FAIL fill_first_issue got=%0d exp=22", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src2 !== 32'hAB) begin failures++; $display("FAIL fill_first_src2 got=%0h exp=ab", rs_if.issue_src2); end
      checks++; if (rs_if.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", rs_if.alloc_ready); end
      tick();
      rs_if.alloc_valid = 1'b0;
      settle();
      checks++; if (rs_if.occupancy !== 4'd7) begin failures++; $display("FAIL fill_occ7 got=%0d exp=7", rs_if.occupancy); end
      checks++; if (rs_if.alloc_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_again got=%0b exp=1", rs_if.alloc_ready); end
      checks++; if (rs_if.issue_rob_tag !== 6'd25) begin failures++; $display("FAIL fill_second_issue got=%0d exp=25", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src1 !== 32'd5) begin failures++; $display("FAIL fill_second_src1 got=%0h exp=5", rs_if.issue_src1); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd6) begin failures++; $display("FAIL fill_occ6 got=%0d exp=6", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL fill_no_stray got=%0b exp=0", rs_if.issue_valid); end
      // Order check: wake the youngest, then the oldest; the oldest must win.
      rs_if.issue_ready = 1'b0;
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd47;
      rs_if.cdb_value = 32'h47;
      tick();
      rs_if.cdb_tag = 6'd40;
      rs_if.cdb_value = 32'h40;
      tick();
      rs_if.cdb_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd20) begin failures++; $display("FAIL order_oldest got=%0d exp=20", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src2 !== 32'h40) begin failures++; $display("FAIL order_oldest_src2 got=%0h exp=40", rs_if.issue_src2); end
      rs_if.issue_ready = 1'b1;
      tick();
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd27) begin failures++; $display("FAIL order_youngest got=%0d exp=27", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src1 !== 32'd7) begin failures++; $display("FAIL order_youngest_src1 got=%0h exp=7", rs_if.issue_src1); end
      checks++; if (rs_if.occupancy !== 4'd5) begin failures++; $display("FAIL order_occ5 got=%0d exp=5", rs_if.occupancy); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd4) begin failures++; $display("FAIL order_occ4 got=%0d exp=4", rs_if.occupancy); end
      rs_if.issue_ready = 1'b0;
      do_flush();
   endtask

   task automatic test_back_to_back();
      rs_if.issue_ready = 1'b0;
      drive_alloc(4'h5, 6'd1, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hA2);
      tick();
      drive_alloc(4'h6, 6'd2, 1'b1, 6'd0, 32'hB1, 1'b0, 6'd33, 32'h0);
      tick();
      // Issue entry 0 while entry 1 shifts down and wakes, and a new entry arrives.
      rs_if.issue_ready = 1'b1;
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd33;
      rs_if.cdb_value = 32'h77;
      drive_alloc(4'h7, 6'd3, 1'b1, 6'd0, 32'hC1, 1'b1, 6'd0, 32'hC2);
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd1) begin failures++; $display("FAIL b2b_first got=%0d exp=1", rs_if.issue_rob_tag); end
      tick();
      rs_if.alloc_valid = 1'b0;
      rs_if.cdb_valid = 1'b0;
      settle();
      checks++; if (rs_if.occupancy !== 4'd2) begin failures++; $display("FAIL b2b_occ_same got=%0d exp=2", rs_if.occupancy); end
      checks++; if (rs_if.issue_rob_tag !== 6'd2) begin failures++; $display("FAIL b2b_shift_wake got=%0d exp=2", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src2 !== 32'h77) begin failures++; $display("FAIL b2b_shift_src2 got=%0h exp=77", rs_if.issue_src2); end
      tick();
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd3) begin failures++; $display("FAIL b2b_new_entry got=%0d exp=3", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src2 !== 32'hC2) begin failures++; $display("FAIL b2b_new_src2 got=%0h exp=c2", rs_if.issue_src2); end
      tick();
      settle();
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", rs_if.occupancy); end
   endtask

   task automatic test_held_issue();
      rs_if.issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_alloc(4'h8, 6'(10 + i), 1'b0, 6'(30 + i), 32'h0, 1'b1, 6'd0, 32'(i));
         tick();
      end
      drive_alloc(4'h9, 6'd13, 1'b1, 6'd0, 32'h31, 1'b1, 6'd0, 32'h32);
      tick();
      rs_if.alloc_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd13) begin failures++; $display("FAIL held_entry3 got=%0d exp=13", rs_if.issue_rob_tag); end
      tick();
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd13) begin failures++; $display("FAIL held_stays got=%0d exp=13", rs_if.issue_rob_tag); end
      rs_if.cdb_valid = 1'b1;
      rs_if.cdb_tag = 6'd30;
      rs_if.cdb_value = 32'h99;
      tick();
      rs_if.cdb_valid = 1'b0;
      settle();
      checks++; if (rs_if.issue_rob_tag !== 6'd10) begin failures++; $display("FAIL held_switch got=%0d exp=10", rs_if.issue_rob_tag); end
      checks++; if (rs_if.issue_src1 !== 32'h99) begin failures++; $display("FAIL held_switch_src1 got=%0h exp=99", rs_if.issue_src1); end
      rs_if.issue_ready = 1'b1;
      tick();
      rs_if.issue_ready = 1'b0;
      settle();
      checks++; if (rs_if.occupancy !== 4'd3) begin failures++; $display("FAIL held_occ3 got=%0d exp=3", rs_if.occupancy); end
      checks++; if (rs_if.issue_rob_tag !== 6'd13) begin failures++; $display("FAIL held_back_to_3 got=%0d exp=13", rs_if.issue_rob_tag); end
      do_flush();
   endtask

   task automatic test_flush();
      rs_if.issue_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_alloc(4'hA, 6'(40 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i));
         tick();
      end
      drive_alloc(4'hB, 6'd44, 1'b1, 6'd0, 32'h44, 1'b1, 6'd0, 32'h44);
      rs_if.flush = 1'b1;
      rs_if.issue_ready = 1'b1;
      settle();
      checks++; if (rs_if.occupancy !== 4'd4) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=4", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle_issue got=%0b exp=0", rs_if.issue_valid); end
      tick();
      rs_if.flush = 1'b0;
      rs_if.alloc_valid = 1'b0;
      settle();
      checks++; if (rs_if.occupancy !== 4'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_issue_valid got=%0b exp=0", rs_if.issue_valid); end
      checks++; if (rs_if.alloc_ready !== 1'b1) begin failures++; $display("FAIL flush_alloc_ready got=%0b exp=1", rs_if.alloc_ready); end
      tick();
      tick();
      settle();
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped_alloc got=%0b tag=%0d exp=0", rs_if.issue_valid, rs_if.issue_rob_tag); end
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_cdb_wakeup();
      test_alloc_bypass();
      test_fill_select();
      test_back_to_back();
      test_held_issue();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Out-of-order ALU reservation station on the receiving end of the dispatch interface. Accepts one renamed ALU/branch micro-op per cycle from dispatch, holds it until both source operands are available, captures missing operands from the common data bus (CDB), and issues the oldest ready entry to the ALU. Entries are kept in an age-ordered collapsing queue, so index 0 is always the oldest.

## Interface
Parameters:
- XLEN, 32, operand width
- RS_SIZE, 8, number of entries (≥2)
- TAG_WIDTH, 6, ROB tag width (matches `rob_alloc_tag`)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict/exception)
- alloc_valid  in  1  dispatch presents a micro-op
- alloc_ready  out  1  station can accept this cycle
- alloc_alu_op  in  4  ALU operation code
- alloc_rob_tag  in  TAG_WIDTH  destination ROB tag
- alloc_src1_value, alloc_src2_value  in  XLEN  operand values, meaningful when the matching ready bit is set
- alloc_src1_ready, alloc_src2_ready  in  1  operand already available
- alloc_src1_tag, alloc_src2_tag  in  TAG_WIDTH  producer ROB tag when not ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  producing ROB tag
- cdb_value  in  XLEN  result value
- issue_valid  out  1  ready entry presented to the ALU
- issue_ready  in  1  ALU accepts
- issue_alu_op  out  4
- issue_src1, issue_src2  out  XLEN
- issue_rob_tag  out  TAG_WIDTH
- occupancy  out  $clog2(RS_SIZE)+1  valid entry count

## Operation
- Entry contents: valid, alu_op, rob_tag, and for each source {ready, tag, value}.
- Allocate on `alloc_valid && alloc_ready && !flush`. The new entry is written at slot `occupancy`, or at `occupancy-1` if an issue fires the same cycle.
- Allocation bypass: if `cdb_valid` and `cdb_tag` equals an incoming not-ready source tag, that source is stored ready with `cdb_value`.
- Wakeup: on every cycle with `cdb_valid`, each valid entry whose not-ready source tag equals `cdb_tag` sets that source ready and latches `cdb_value`. Already-ready sources are never overwritten.
- Select: combinationally pick the lowest-index valid entry with both sources ready. `issue_valid`=1 iff such an entry exists and `flush`=0. The issue_* fields come from that entry; all are 0 when `issue_valid`=0.
- Issue fires on `issue_valid && issue_ready`. The issued entry is removed, and every entry above it shifts down one slot, keeping age order. Wakeup applies to entries while they shift.
- `alloc_ready` = (occupancy < RS_SIZE). There is no credit for a same-cycle issue.
- `flush`: at the next edge, all valid bits clear and occupancy = 0. An allocation in the flush cycle is dropped.
- Reset: same effect as flush. Outputs after reset: alloc_ready=1, issue_valid=0, issue fields 0, occupancy=0.

## Timing
- Minimum allocate-to-issue latency is 1 cycle. An entry written at edge N (sources ready, or bypassed from the CDB) can assert `issue_valid` in cycle N+1 and no earlier.
- A CDB wakeup at edge N makes the entry issuable in cycle N+1.
- Simultaneous allocate and issue while full: `alloc_ready`=0, so only the issue happens. Occupancy drops to RS_SIZE-1 and `alloc_ready`=1 the next cycle.
- Simultaneous allocate and issue while not full: occupancy is unchanged, and the new entry lands directly above the surviving entries.
- Held issue (`issue_ready`=0): the same entry stays presented unless an older entry becomes ready, in which case the older entry takes precedence.
- `rst` and `flush` take priority over all other updates in the same cycle.

## Test plan
- Reset, then allocate op=ADD, tag 5, src1=3, src2=4, both ready. Expect `issue_valid`=1 the next cycle with src1=3, src2=4, rob_tag=5, and occupancy 1→0 after the issue.
- Allocate tag 7 with src2 waiting on tag 12, then drive CDB tag 12 = 0xDEAD two cycles later. Expect `issue_valid` the cycle after the CDB, with issue_src2=0xDEAD.
- Allocate while CDB tag 9 = 0x55 in the same cycle, with src1 tag 9 not ready. Expect the entry to issue the next cycle with src1=0x55.
- Fill 8 entries with sources not ready. Expect `alloc_ready`=0 and occupancy=8. Wake entries 2 and 5 together and expect entry 2 to issue first, then 5. Occupancy reaches 6, and the remaining entries stay in order.
- Hold `issue_ready`=0 with entry 3 ready, then wake entry 0. Expect the issue to switch to entry 0's rob_tag.
- With 4 entries valid, assert `flush` together with `alloc_valid`. Expect occupancy=0, `issue_valid`=0 and `alloc_ready`=1 the next cycle, and the flushed-cycle allocation never issues.
